// File: rtl/lc3b_fetch_stage_pkg.sv
// lc3b_fetch_stage_pkg: shared LC-3b fetch types, line geometry and address helpers.
package lc3b_fetch_stage_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    localparam int LC3B_LINE_WORDS = 8;

    typedef enum logic {
        FETCH_RUN,
        FETCH_FILL
    } lc3b_fetch_state;

    typedef struct packed {
        logic     valid;
        lc3b_word pc;
        lc3b_word pc_plus2;
        lc3b_word instr;
    } lc3b_if_id;

    function automatic lc3b_word line_base(input lc3b_word addr);
        return {addr[15:4], 4'h0};
    endfunction

    function automatic lc3b_word even_addr(input lc3b_word addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/lc3b_fetch_stage_line_buffer.sv
// lc3b_line_buffer: single-line instruction buffer with tag compare and word select.
module lc3b_line_buffer
    import lc3b_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [11:0] load_tag,
    input  lc3b_line    load_data,
    input  logic [11:0] lookup_tag,
    input  logic [2:0]  word_sel,
    output logic        hit,
    output lc3b_word    word
);

    logic        valid;
    logic [11:0] tag;
    lc3b_line    data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tag   <= load_tag;
            data  <= load_data;
        end
    end

    assign hit  = valid && tag == lookup_tag;
    assign word = data[{word_sel, 4'h0} +: 16];

endmodule

// File: rtl/lc3b_fetch_stage.sv
// lc3b_fetch_stage: LC-3b instruction fetch with one-line buffer, stall and redirect.
module lc3b_fetch_stage
    import lc3b_fetch_stage_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     stall,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    output logic     imem_read,
    output lc3b_word imem_addr,
    input  logic     imem_resp,
    input  lc3b_line imem_rdata,
    output logic     if_valid,
    output lc3b_word if_instr,
    output lc3b_word if_pc,
    output lc3b_word if_pc_plus2
);

    lc3b_fetch_state state;
    lc3b_word        pc;
    lc3b_if_id       if_id;
    logic            hit;
    lc3b_word        word;
    logic            fill_done;

    assign fill_done = state == FETCH_FILL && imem_resp;

    lc3b_line_buffer u_line_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (fill_done),
        .load_tag   (imem_addr[15:4]),
        .load_data  (imem_rdata),
        .lookup_tag (pc[15:4]),
        .word_sel   (pc[3:1]),
        .hit        (hit),
        .word       (word)
    );

    // A fill in flight always completes, even when a redirect lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH_RUN;
            pc        <= even_addr(RESET_PC);
            if_id     <= '0;
            imem_read <= 1'b0;
            imem_addr <= '0;
        end else begin
            if (redirect) begin
                pc          <= even_addr(redirect_pc);
                if_id.valid <= 1'b0;
            end else if (state == FETCH_RUN && !stall) begin
                if (hit) begin
                    if_id <= '{valid: 1'b1, pc: pc, pc_plus2: pc + 16'd2, instr: word};
                    pc    <= pc + 16'd2;
                end else begin
                    if_id.valid <= 1'b0;
                    imem_read   <= 1'b1;
                    imem_addr   <= line_base(pc);
                    state       <= FETCH_FILL;
                end
            end
            if (fill_done) begin
                imem_read <= 1'b0;
                state     <= FETCH_RUN;
            end
        end
    end

    assign if_valid    = if_id.valid;
    assign if_instr    = if_id.instr;
    assign if_pc       = if_id.pc;
    assign if_pc_plus2 = if_id.pc_plus2;

endmodule
